iterative_muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide unit that extends the single-cycle 32-bit ALU with MULT/MULTU/DIV/DIVU and HI/LO result registers.
- Sits beside the main ALU in the MIPS datapath; the controller pulses start, then stalls the PC until done.
- Shift-add multiply and restoring divide, one bit per cycle; signed ops are handled by magnitude conversion plus a final sign-fix cycle.

---
 rtl/iterative_muldiv_unit_if.sv | 26 ++
 rtl/iterative_muldiv_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// Purpose: request/result bundle between the MIPS controller and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none; the controller holds off new requests while busy is high.
interface iterative_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU with HI/LO result registers (shift-add / restoring divide).
// Latency: WIDTH RUN cycles + 1 sign-fix cycle; done pulses after edge E_(WIDTH+1).
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
// Optional: define MULDIV_EARLY_TERM_EN to end multiplies once no multiplier bits remain.
module iterative_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  iterative_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg;       // quotient / product sign
  logic                 r_a_neg;     // remainder sign follows the dividend
  logic                 r_bz;
  logic [WIDTH-1:0]     r_a_orig;
  logic [WIDTH-1:0]     r_mp;        // multiplier (shifts right) or divisor (static)
  logic [2*WIDTH-1:0]   r_mc;        // multiplicand, shifted left each step
  logic [2*WIDTH:0]     r_acc;       // product, or {remainder, quotient} for divide
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // Operand magnitudes for signed ops
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b = w_b_neg ? -bus.b : bus.b;

  // Multiply step: add the shifted multiplicand when the current multiplier bit is set
  logic [2*WIDTH:0] w_mul_acc;
  assign w_mul_acc = r_acc + (r_mp[0] ? {1'b0, r_mc} : '0);

  // Restoring divide step: shift in the next dividend bit, subtract if it fits
  logic [2*WIDTH:0] w_acc_sh;
  logic [WIDTH:0]   w_rem_sh, w_dvs, w_trial;
  logic             w_ge;
  logic [2*WIDTH:0] w_div_acc;
  assign w_acc_sh  = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_rem_sh  = w_acc_sh[2*WIDTH:WIDTH];
  assign w_dvs     = {1'b0, r_mp};
  assign w_ge      = (w_rem_sh >= w_dvs);
  assign w_trial   = w_rem_sh - w_dvs;
  assign w_div_acc = w_ge ? {w_trial, w_acc_sh[WIDTH-1:1], 1'b1} : w_acc_sh;

  // Multiplies may stop once the bit being consumed is the last set multiplier bit
  logic w_early;
`ifdef MULDIV_EARLY_TERM_EN
  assign w_early = !r_is_div && (r_mp[WIDTH-1:1] == '0);
`else
  assign w_early = 1'b0;
`endif

  logic w_last;
  assign w_last = (r_cnt == CW'(1)) || w_early;

  // Sign-fixed results presented in FIX
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_q, w_r, w_q_s, w_r_s;
  assign w_prod   = r_acc[2*WIDTH-1:0];
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_q      = r_acc[WIDTH-1:0];
  assign w_r      = r_acc[2*WIDTH-1:WIDTH];
  assign w_q_s    = r_neg ? -w_q : w_q;
  assign w_r_s    = r_a_neg ? -w_r : w_r;

  // Control FSM, datapath iteration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_bz     <= 1'b0;
      r_a_orig <= '0;
      r_mp     <= '0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_is_div <= bus.op[1];
            r_neg    <= w_a_neg ^ w_b_neg;
            r_a_neg  <= w_a_neg;
            r_bz     <= (bus.b == '0);
            r_a_orig <= bus.a;
            r_mp     <= w_abs_b;
            r_mc     <= {{WIDTH{1'b0}}, w_abs_a};
            r_acc    <= bus.op[1] ? {{(WIDTH+1){1'b0}}, w_abs_a} : '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc <= w_mul_acc;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
          end
          if (w_last) r_state <= S_FIX;
          else        r_cnt   <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_s;
            r_dbz        <= 1'b0;
          end else if (r_bz) begin
            r_hi  <= r_a_orig;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi  <= w_r_s;
            r_lo  <= w_q_s;
            r_dbz <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule
